// File: rtl/bingo_pkg.sv
// bingo_pkg: shared defaults, LFSR taps and draw FSM states for number_draw
package bingo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_NUMBER_DEF = 99;
  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_BTN,
    ST_DRAW,
    ST_CHECK,
    ST_COMMIT,
    ST_DONE
  } draw_state_e;
endpackage

// File: rtl/number_draw_btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, optional debounce (DRAW_DEBOUNCE_EN), rising-edge pulse
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_pulse
);
  logic [1:0] sync;
  logic level, level_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], btn};
`ifdef DRAW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  // level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level <= 1'b0;
      cnt <= '0;
    end else if (sync[1] == level) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync[1];
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
`else
  logic unused_debounce;
  assign unused_debounce = DEBOUNCE_CYCLES[0];
  assign level = sync[1];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level_q <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      level_q <= level;
      btn_pulse <= level & ~level_q;
    end
endmodule

// File: rtl/number_draw.sv
// number_draw: draws non-repeating pseudo-random numbers 1..MAX_NUMBER on button presses
// Build option: DRAW_DEBOUNCE_EN enables the button debounce counter.
module number_draw import bingo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_NUMBER = MAX_NUMBER_DEF,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED = DATA_WIDTH'(8'hA5),
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(LFSR_TAPS_8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_game,
  input  logic                  next_btn,
  input  logic                  endgame,
  output logic [DATA_WIDTH-1:0] guessed_number,
  output logic                  next_edge,
  output logic [DATA_WIDTH-1:0] draw_count,
  output logic                  all_drawn,
  output logic                  busy
);
  localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(MAX_NUMBER);
  draw_state_e state, state_nx;
  logic btn_pulse, end_seen, cand_ok;
  logic [DATA_WIDTH-1:0] lfsr, cand;
  logic [MAX_NUMBER:1] drawn, cand_hot;
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn      (next_btn),
    .btn_pulse(btn_pulse)
  );
  // one-hot of cand; all-zero when cand is outside 1..MAX_NUMBER
  for (genvar i = 1; i <= MAX_NUMBER; i++) begin : g_hot
    assign cand_hot[i] = cand == DATA_WIDTH'(i);
  end
  assign cand_ok = |cand_hot && !(|(drawn & cand_hot));
  assign all_drawn = draw_count == MAXV;
  assign busy = state inside {ST_DRAW, ST_CHECK, ST_COMMIT};
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[DATA_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     state_nx = start_game ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:    state_nx = ST_WAIT_BTN;
      ST_WAIT_BTN: state_nx = endgame ? ST_DONE : btn_pulse ? ST_DRAW : ST_WAIT_BTN;
      ST_DRAW:     state_nx = ST_CHECK;
      ST_CHECK:    state_nx = cand_ok ? ST_COMMIT : ST_CHECK;
      ST_COMMIT:   state_nx = (all_drawn || end_seen || endgame) ? ST_DONE : ST_WAIT_BTN;
      ST_DONE:     state_nx = start_game ? ST_CLEAR : ST_DONE;
      default:     state_nx = ST_IDLE;
    endcase
  end
  // commit registers load on CHECK->COMMIT so next_edge and guessed_number change together
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cand <= '0;
      drawn <= '0;
      guessed_number <= '0;
      next_edge <= 1'b0;
      draw_count <= '0;
      end_seen <= 1'b0;
    end else begin
      next_edge <= 1'b0;
      if (state == ST_CLEAR) begin
        drawn <= '0;
        draw_count <= '0;
        end_seen <= 1'b0;
      end
      if (busy && endgame) end_seen <= 1'b1;
      if (state == ST_DRAW) cand <= lfsr;
      if (state == ST_CHECK) begin
        if (cand_ok) begin
          drawn <= drawn | cand_hot;
          guessed_number <= cand;
          next_edge <= 1'b1;
          draw_count <= draw_count + 1'b1;
        end else cand <= (cand >= MAXV) ? DATA_WIDTH'(1) : cand + 1'b1;
      end
    end
endmodule

// File: tb/tb_number_draw.sv
// tb_number_draw: directed sequence with a behavioural draw model (LFSR + search over a bitmap)
module tb_number_draw;
  localparam int MAXN = 5;
  logic clk = 1'b0, rst = 1'b1, start_game = 1'b0, next_btn = 1'b0, endgame = 1'b0;
  logic [7:0] guessed_number, draw_count;
  logic next_edge, all_drawn, busy;
  logic [7:0] lfsr_m;
  bit drawn_m [1:MAXN];
  int cnt_m = 0, passed = 0, total = 0, fails = 0;

  always #5 clk = ~clk;

  number_draw #(.DATA_WIDTH(8), .MAX_NUMBER(MAXN), .DEBOUNCE_CYCLES(4), .LFSR_SEED(8'hA5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_game    (start_game),
    .next_btn      (next_btn),
    .endgame       (endgame),
    .guessed_number(guessed_number),
    .next_edge     (next_edge),
    .draw_count    (draw_count),
    .all_drawn     (all_drawn),
    .busy          (busy)
  );

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, stepping on every clock out of reset
  always @(posedge clk) lfsr_m <= rst ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 1; i <= MAXN; i++) drawn_m[i] = 0;
    cnt_m = 0;
  endtask

  task automatic start();
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    chk("start count", draw_count, 0);
  endtask

  // drive a button pattern, predict the drawn number and its cycle from the model
  task automatic press(input logic [15:0] pat, input int exp_pulses, input string tag);
    int pulses, exp_cyc, k;
    logic [7:0] exp_num, v;
    logic prev_busy;
    pulses = 0;
    exp_cyc = -1;
    exp_num = 8'd0;
    prev_busy = busy;
    for (int c = 0; c < 40; c++) begin
      next_btn = c < 16 && pat[c[3:0]];
      @(negedge clk);
      if (busy && !prev_busy) begin
        v = lfsr_m;
        k = 0;
        while (!(v >= 1 && v <= MAXN && !drawn_m[v]) && k <= MAXN + 1) begin
          v = (v >= MAXN) ? 8'd1 : v + 8'd1;
          k++;
        end
        exp_num = v;
        exp_cyc = c + 2 + k;
      end
      prev_busy = busy;
      if (next_edge) begin
        pulses++;
        chk({tag, " value"}, guessed_number, exp_num);
        chk({tag, " latency"}, c, exp_cyc);
        if (exp_num >= 1 && exp_num <= MAXN) drawn_m[exp_num] = 1;
        cnt_m++;
      end
    end
    next_btn = 1'b0;
    chk({tag, " pulses"}, pulses, exp_pulses);
    chk({tag, " count"}, draw_count, cnt_m);
    chk({tag, " all_drawn"}, all_drawn, cnt_m == MAXN);
  endtask

  initial begin
    bit found;
    int pulses;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset guessed", guessed_number, 0);
    chk("reset next_edge", next_edge, 0);
    chk("reset count", draw_count, 0);
    chk("reset all_drawn", all_drawn, 0);
    chk("reset busy", busy, 0);
    press(16'h00FF, 0, "idle press");
    start();
    for (int i = 0; i < MAXN; i++) press(16'h00FF, 1, "draw");
    press(16'h00FF, 0, "exhausted press");
    chk("exhausted busy", busy, 0);
    start();
`ifdef DRAW_DEBOUNCE_EN
    press(16'h0007, 0, "glitch");
`endif
    press(16'h003F, 1, "press6");
    endgame = 1'b1;
    @(negedge clk);
    endgame = 1'b0;
    @(negedge clk);
    press(16'h00FF, 0, "after endgame");
    start();
    press(16'h00FF, 1, "restart draw");
`ifndef DRAW_DEBOUNCE_EN
    press(16'h0005, 1, "drop");
`else
    press(16'h00FF, 1, "second draw");
`endif
    next_btn = 1'b1;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      found = busy;
    end
    chk("mid-draw reached", found, 1);
    rst = 1'b1;
    next_btn = 1'b0;
    @(negedge clk);
    chk("mid reset guessed", guessed_number, 0);
    chk("mid reset next_edge", next_edge, 0);
    chk("mid reset count", draw_count, 0);
    chk("mid reset busy", busy, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (next_edge) pulses++;
    end
    chk("no commit after reset", pulses, 0);
    clear_model();
    start();
    press(16'h00FF, 1, "post reset draw");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
